// File: rtl/fetch_pkg.sv
// Shared constants and payload type for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned PC_INCR = 4;

    localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO skid buffer holding fetched {pc, instr} pairs for decode.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t second;

    // Head is the oldest entry and is kept in a register so decode sees stable data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count  <= 2'd0;
            head   <= '0;
            second <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= push_entry;
                    end else begin
                        second <= push_entry;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= second;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= push_entry;
                    end else begin
                        head   <= second;
                        second <= push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    // The upstream issue rule keeps occupancy within two entries.
    a_count_bound: assert property (@(posedge clock) disable iff (!reset_n)
        count <= 2'd2);
    a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(push && !pop && !flush && count == 2'd2));

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage in front of a 1-cycle synchronous ROM.
// Optional macro IFETCH_PERF_EN adds fetch_count / stall_count performance counters.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned              ADDRESS_WIDTH = ADDR_W,
    parameter int unsigned              DATA_WIDTH    = DATA_W,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
)(
    input  logic                     clock,
    input  logic                     reset_n,
    output logic [ADDRESS_WIDTH-1:0] rom_address,
    input  logic [DATA_WIDTH-1:0]    rom_q,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [DATA_WIDTH-1:0]    instr_data,
    output logic [ADDRESS_WIDTH-1:0] instr_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]              fetch_count,
    output logic [31:0]              stall_count
`endif
);

    logic [ADDRESS_WIDTH-1:0] pc;
    logic [ADDRESS_WIDTH-1:0] inflight_pc;
    logic                     inflight;
    logic                     pop;
    logic                     push;
    logic                     issue;
    logic [1:0]               buf_count;
    logic [2:0]               occupancy;
    fetch_entry_t             push_entry;
    fetch_entry_t             head;
    logic                     unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // A taken redirect bypasses the sequential pc straight onto the ROM address.
    always_comb begin
        rom_address = pc;
        if (redirect_valid) begin
            rom_address = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
        end
    end

    assign instr_valid = (buf_count != 2'd0);
    assign pop         = instr_valid && instr_ready;
    assign push        = inflight && !redirect_valid;

    // Issue only while the buffer can absorb the word returning next cycle.
    assign occupancy = 3'(buf_count) + 3'(inflight) - 3'(pop);
    assign issue     = redirect_valid || (occupancy <= 3'd1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (issue) begin
            pc          <= rom_address + ADDRESS_WIDTH'(PC_INCR);
            inflight    <= 1'b1;
            inflight_pc <= rom_address;
        end else begin
            inflight <= 1'b0;
        end
    end

    always_comb begin
        push_entry       = '0;
        push_entry.pc    = ADDR_W'(inflight_pc);
        push_entry.instr = DATA_W'(rom_q);
    end

    fetch_skid_buf u_skid_buf (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_valid),
        .push_entry (push_entry),
        .count      (buf_count),
        .head       (head)
    );

    assign instr_data = DATA_WIDTH'(head.instr);
    assign instr_pc   = ADDRESS_WIDTH'(head.pc);

`ifdef IFETCH_PERF_EN
    // Free-running counters; wrap naturally at 2^32.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            if (pop) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (instr_valid && !instr_ready) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, random stream scoreboard, async reset.
module tb_instr_fetch;
    import fetch_pkg::*;

    localparam int unsigned AW     = 8;
    localparam int unsigned DW     = 32;
    localparam int unsigned NWORDS = 64;
    localparam int unsigned NVEC   = 27;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] rom_address;
    logic [DW-1:0] rom_q;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [DW-1:0] instr_data;
    logic [AW-1:0] instr_pc;
`ifdef IFETCH_PERF_EN
    logic [31:0]   fetch_count;
    logic [31:0]   stall_count;
`endif

    logic [DW-1:0] mem [NWORDS];

    typedef struct {
        logic          ready;
        logic          rv;
        logic [AW-1:0] rpc;
        logic          chk;
        logic          ev;
        logic [AW-1:0] epc;
        logic [DW-1:0] edata;
        logic [AW-1:0] erom;
    } vec_t;

    vec_t vecs [NVEC];

    int total  = 0;
    int passed = 0;

    instr_fetch dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .rom_address    (rom_address),
        .rom_q          (rom_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
`ifdef IFETCH_PERF_EN
        ,
        .fetch_count    (fetch_count),
        .stall_count    (stall_count)
`endif
    );

    always #5 clock = ~clock;

    // Synchronous ROM: one-cycle registered read.
    always @(posedge clock) rom_q <= mem[rom_address[AW-1:2]];

    function automatic logic [DW-1:0] w(input int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    function automatic vec_t mk(input logic r, input logic rv, input logic [AW-1:0] rpc,
                                input logic chk, input logic ev, input logic [AW-1:0] epc,
                                input logic [DW-1:0] ed, input logic [AW-1:0] erom);
        vec_t v;
        v.ready = r;   v.rv  = rv;  v.rpc   = rpc;
        v.chk   = chk; v.ev  = ev;  v.epc   = epc;
        v.edata = ed;  v.erom = erom;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] exp_next;
        int pops;
        int exp_fetch;
        int exp_stall;

        for (int i = 0; i < int'(NWORDS); i++) mem[i] = NOP_INSTR;
        for (int i = 0; i < int'(NWORDS); i++) mem[i] = w(i);

        // Reset release, stall at 0x10, redirect while full, wrap past 0xFC.
        vecs[0]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0,  8'h00);
        vecs[1]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0,  8'h04);
        vecs[2]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, w(0),   8'h08);
        vecs[3]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h04, w(1),   8'h0C);
        vecs[4]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h08, w(2),   8'h10);
        vecs[5]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h0C, w(3),   8'h14);
        for (int i = 6; i <= 10; i++)
            vecs[i] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h10, w(4), 8'h18);
        vecs[11] = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h10, w(4),   8'h18);
        vecs[12] = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h14, w(5),   8'h1C);
        vecs[13] = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h18, w(6),   8'h20);
        vecs[14] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h1C, w(7),   8'h24);
        vecs[15] = mk(1'b0, 1'b1, 8'h41, 1'b1, 1'b1, 8'h1C, w(7),   8'h40);
        vecs[16] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0,  8'h44);
        vecs[17] = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h40, w(16),  8'h48);
        vecs[18] = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h44, w(17),  8'h4C);
        vecs[19] = mk(1'b1, 1'b1, 8'hF0, 1'b1, 1'b1, 8'h48, w(18),  8'hF0);
        vecs[20] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0,  8'hF4);
        vecs[21] = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'hF0, w(60),  8'hF8);
        vecs[22] = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'hF4, w(61),  8'hFC);
        vecs[23] = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'hF8, w(62),  8'h00);
        vecs[24] = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFC, w(63),  8'h04);
        vecs[25] = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, w(0),   8'h08);
        vecs[26] = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h04, w(1),   8'h0C);

        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        exp_fetch = 0;
        exp_stall = 0;
        for (int i = 0; i < int'(NVEC); i++) begin
            instr_ready    = vecs[i].ready;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            #1;
            check($sformatf("vec%0d valid", i), 32'(instr_valid), 32'(vecs[i].ev));
            check($sformatf("vec%0d rom_address", i), 32'(rom_address), 32'(vecs[i].erom));
            if (vecs[i].chk) begin
                check($sformatf("vec%0d instr_pc", i), 32'(instr_pc), 32'(vecs[i].epc));
                check($sformatf("vec%0d instr_data", i), instr_data, vecs[i].edata);
            end
            if (vecs[i].ev && vecs[i].ready) exp_fetch++;
            if (vecs[i].ev && !vecs[i].ready) exp_stall++;
            @(posedge clock);
            @(negedge clock);
        end
        redirect_valid = 1'b0;
`ifdef IFETCH_PERF_EN
        check("fetch_count after table", fetch_count, 32'(exp_fetch));
        check("stall_count after table", stall_count, 32'(exp_stall));
`endif

        // Random ready and redirects against an expected-pc scoreboard.
        exp_next = 8'h08;
        pops = 0;
        for (int c = 0; c < 1000; c++) begin
            instr_ready    = 1'($urandom_range(0, 1));
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = AW'($urandom);
            #1;
            if (instr_valid && instr_ready) begin
                pops++;
                check("rand instr_pc", 32'(instr_pc), 32'(exp_next));
                check("rand instr_data", instr_data, mem[exp_next[AW-1:2]]);
                exp_next = exp_next + 8'd4;
            end
            if (redirect_valid) exp_next = {redirect_pc[AW-1:2], 2'b00};
            @(posedge clock);
            @(negedge clock);
        end
        check("rand progress", 32'(pops >= 200), 32'd1);

        // Fill the buffer, then pulse reset asynchronously mid-stream.
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        repeat (3) begin
            @(posedge clock);
            @(negedge clock);
        end
        #1;
        check("pre-reset valid", 32'(instr_valid), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("async reset valid", 32'(instr_valid), 32'd0);
        check("async reset rom_address", 32'(rom_address), 32'h00);
        check("async reset instr_pc", 32'(instr_pc), 32'h00);
        check("async reset instr_data", instr_data, 32'h0);
`ifdef IFETCH_PERF_EN
        check("reset fetch_count", fetch_count, 32'd0);
        check("reset stall_count", stall_count, 32'd0);
`endif
        instr_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("restart c0 valid", 32'(instr_valid), 32'd0);
        check("restart c0 rom_address", 32'(rom_address), 32'h00);
        @(posedge clock); @(negedge clock); #1;
        check("restart c1 valid", 32'(instr_valid), 32'd0);
        check("restart c1 rom_address", 32'(rom_address), 32'h04);
        @(posedge clock); @(negedge clock); #1;
        check("restart c2 valid", 32'(instr_valid), 32'd1);
        check("restart c2 instr_pc", 32'(instr_pc), 32'h00);
        check("restart c2 instr_data", instr_data, w(0));
        @(posedge clock); @(negedge clock); #1;
        check("restart c3 instr_pc", 32'(instr_pc), 32'h04);
        check("restart c3 instr_data", instr_data, w(1));
`ifdef IFETCH_PERF_EN
        check("restart fetch_count", fetch_count, 32'd1);
        check("restart stall_count", stall_count, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
